// File: rtl/unidade_entrada_saida_pkg.sv
// Shared definitions for the I/O stage:
//   - display FSM state encoding
//   - seven-segment constants: blank pattern and the 0-9 digit table
//   - BCD nibble-adjust helper used by the double-dabble converter
package entrada_saida_pkg;

  typedef enum logic [1:0] {
    OCIOSO   = 2'b00,
    CONVERTE = 2'b01,
    EXIBE    = 2'b10
  } estadoDisplay_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Index 9 is listed first because this is a packed [9:0] array
  localparam logic [9:0][6:0] SEG_TABLE = '{
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  // Double-dabble correction: a nibble >= 5 becomes >= 10 after the shift,
  // so add 3 beforehand to carry into the next decimal digit
  function automatic logic [3:0] ajustaBcd(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] codificaDigito(input logic [3:0] d);
    return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/unidade_entrada_saida_if.sv
// Handshake/data bundle between the control unit and the I/O stage.
//   master (control unit): drives sinalIn, sinalDisplay, dadoSaida
//   slave  (I/O stage)   : drives confirmaEntrada, dadoEntrada
interface unidade_entrada_saida_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  sinalIn;
  logic                  sinalDisplay;
  logic [DATA_WIDTH-1:0] dadoSaida;
  logic                  confirmaEntrada;
  logic [DATA_WIDTH-1:0] dadoEntrada;

  modport master (
    output sinalIn, sinalDisplay, dadoSaida,
    input  confirmaEntrada, dadoEntrada
  );

  modport slave (
    input  sinalIn, sinalDisplay, dadoSaida,
    output confirmaEntrada, dadoEntrada
  );
endinterface

// File: rtl/unidade_entrada_saida_debouncer.sv
// Confirm-button conditioning: 2-flop synchronizer, stability counter and
// rising-edge pulse generator.
//   clock, reset : system clock, synchronous active-high reset
//   botaoRaw     : raw asynchronous button, 1 = pressed
//   pulso        : one-cycle pulse per accepted press (none on release)
module debouncer_botao #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic botaoRaw,
  output logic pulso
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1, sync2;
  logic          nivel;
  logic [CW-1:0] contador;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      nivel    <= 1'b0;
      contador <= '0;
      pulso    <= 1'b0;
    end else begin
      sync1 <= botaoRaw;
      sync2 <= sync1;
      pulso <= 1'b0;
      if (sync2 == nivel) begin
        contador <= '0;
      end else if (contador == CW'(DEBOUNCE_CYCLES - 1)) begin
        // This increment would reach DEBOUNCE_CYCLES: accept the new level
        nivel    <= sync2;
        contador <= '0;
        pulso    <= sync2;   // only the 0->1 transition pulses
      end else begin
        contador <= contador + 1'b1;
      end
    end
  end

endmodule

// File: rtl/unidade_entrada_saida.sv
// Peripheral I/O stage next to the multicycle control unit.
//   clock, reset      : system clock, synchronous active-high reset
//   botaoRaw          : raw confirm button -> debounced confirmaEntrada pulse
//   chaves            : switch word, captured into dadoEntrada on a pulse during IN
//   cpu (slave)       : sinalIn/sinalDisplay/dadoSaida in, confirmaEntrada/dadoEntrada out
//   aguardandoEntrada : LED, registered copy of sinalIn
//   displayBusy       : serial conversion in progress
//   segmentos         : NUM_DIGITS active-low 7-seg digits, digit 0 least significant
//   sinalNegativo     : minus-sign LED
module unidade_entrada_saida
  import entrada_saida_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_DIGITS      = 5,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    botaoRaw,
  input  logic [DATA_WIDTH-1:0]   chaves,
  unidade_entrada_saida_if.slave  cpu,
  output logic                    aguardandoEntrada,
  output logic                    displayBusy,
  output logic [7*NUM_DIGITS-1:0] segmentos,
  output logic                    sinalNegativo
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [7*NUM_DIGITS-1:0] SEG_RESET = {{(NUM_DIGITS-1){SEG_BLANK}}, SEG_TABLE[0]};

  // ---------------- button and input capture ----------------
  debouncer_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uDebouncer (
    .clock    (clock),
    .reset    (reset),
    .botaoRaw (botaoRaw),
    .pulso    (cpu.confirmaEntrada)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu.dadoEntrada   <= '0;
      aguardandoEntrada <= 1'b0;
    end else begin
      aguardandoEntrada <= cpu.sinalIn;
      if (cpu.confirmaEntrada && cpu.sinalIn)
        cpu.dadoEntrada <= chaves;
    end
  end

  // ---------------- display conversion ----------------
  estadoDisplay_t        estado, proxEstado;
  logic [DATA_WIDTH-1:0] mag, proxMag;
  logic [BW-1:0]         bcd, proxBcd, bcdAjustado;
  logic [CW-1:0]         contShift, proxCont;
  logic                  neg, proxNeg;
  logic                  atualiza;
  logic [7*NUM_DIGITS-1:0] segCalc;

  always_comb begin
    proxEstado = estado;
    proxMag    = mag;
    proxBcd    = bcd;
    proxCont   = contShift;
    proxNeg    = neg;
    atualiza   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      bcdAjustado[4*i +: 4] = ajustaBcd(bcd[4*i +: 4]);

    if (cpu.sinalDisplay) begin
      // New request wins in every state, including an ongoing conversion.
      // Negating the most negative value yields 2^(DATA_WIDTH-1), which is
      // the correct unsigned magnitude.
      proxNeg    = cpu.dadoSaida[DATA_WIDTH-1];
      proxMag    = cpu.dadoSaida[DATA_WIDTH-1] ? -cpu.dadoSaida : cpu.dadoSaida;
      proxBcd    = '0;
      proxCont   = CW'(DATA_WIDTH);
      proxEstado = CONVERTE;
    end else if (estado == CONVERTE) begin
      if (contShift != '0) begin
        {proxBcd, proxMag} = {bcdAjustado, mag} << 1;
        proxCont           = contShift - 1'b1;
      end else begin
        atualiza   = 1'b1;
        proxEstado = EXIBE;
      end
    end
  end

  // Leading-zero blanking: scan from the top digit; digit 0 always shown
  always_comb begin
    logic visto;
    visto   = 1'b0;
    segCalc = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (bcd[4*i +: 4] != 4'd0) visto = 1'b1;
      segCalc[7*i +: 7] = (visto || i == 0) ? codificaDigito(bcd[4*i +: 4]) : SEG_BLANK;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado        <= OCIOSO;
      mag           <= '0;
      bcd           <= '0;
      contShift     <= '0;
      neg           <= 1'b0;
      displayBusy   <= 1'b0;
      segmentos     <= SEG_RESET;
      sinalNegativo <= 1'b0;
    end else begin
      estado      <= proxEstado;
      mag         <= proxMag;
      bcd         <= proxBcd;
      contShift   <= proxCont;
      neg         <= proxNeg;
      displayBusy <= (proxEstado == CONVERTE);
      if (atualiza) begin
        segmentos     <= segCalc;
        sinalNegativo <= neg && (bcd != '0);   // never show "-0"
      end
    end
  end

endmodule
